// File: rtl/apb_mem_mp.sv
// Multi-port APB memory: CPU_NB APB subordinate ports share one word-organised
// memory. Requests are granted round-robin and served one at a time. Each
// transfer can add wait states, uses byte strobes on writes, and returns an
// error for word indices at or beyond DEPTH.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   i_apb_s_psel       per-port select
//   i_apb_s_penable    per-port enable
//   i_apb_s_paddr      per-port byte address
//   i_apb_s_pwrite     per-port direction, 1 = write
//   i_apb_s_pwdata     per-port write data
//   i_apb_s_pstrb      per-port write byte strobes
//   o_apb_s_pready     per-port transfer complete (registered)
//   o_apb_s_prdata     per-port read data (registered)
//   o_apb_s_pslverr    per-port error response (registered)
module apb_mem_mp #(
    parameter int unsigned CPU_NB      = 4,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [CPU_NB-1:0]                i_apb_s_psel,
    input  logic [CPU_NB-1:0]                i_apb_s_penable,
    input  logic [CPU_NB-1:0][ADDR_W-1:0]    i_apb_s_paddr,
    input  logic [CPU_NB-1:0]                i_apb_s_pwrite,
    input  logic [CPU_NB-1:0][DATA_W-1:0]    i_apb_s_pwdata,
    input  logic [CPU_NB-1:0][DATA_W/8-1:0]  i_apb_s_pstrb,
    output logic [CPU_NB-1:0]                o_apb_s_pready,
    output logic [CPU_NB-1:0][DATA_W-1:0]    o_apb_s_prdata,
    output logic [CPU_NB-1:0]                o_apb_s_pslverr
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF_W  = (STRB_W > 1) ? $clog2(STRB_W) : 0;
    localparam int unsigned GNT_W  = (CPU_NB > 1) ? $clog2(CPU_NB) : 1;
    localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned CMP_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic [GNT_W-1:0]                gnt_q, gnt_d;
    logic [GNT_W-1:0]                rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [ADDR_W-1:0]               addr_q, addr_d;
    logic                            write_q, write_d;
    logic [DATA_W-1:0]               wdata_q, wdata_d;
    logic [STRB_W-1:0]               strb_q, strb_d;
    logic [DATA_W-1:0]               rdata_q, rdata_d;
    logic                            err_q, err_d;
    logic [CPU_NB-1:0]               pready_q, pready_d;
    logic [CPU_NB-1:0][DATA_W-1:0]   prdata_q, prdata_d;
    logic [CPU_NB-1:0]               pslverr_q, pslverr_d;

    logic [DATA_W-1:0]               mem [DEPTH];
    logic [ADDR_W-1:0]               idx;
    logic                            in_range;
    logic [DATA_W-1:0]               mem_rd;
    logic                            mem_we;

    logic                            any_req;
    logic [GNT_W-1:0]                win;
    logic [GNT_W-1:0]                cand;

    // Word index of the captured address and its range check
    always_comb begin
        idx      = addr_q >> OFF_W;
        in_range = ({1'b0, idx} < CMP_W'(DEPTH));
        mem_rd   = mem[idx[MEM_AW-1:0]];
    end

    // Round-robin pick: first requesting port at or above rr_ptr, wrapping
    always_comb begin
        any_req = 1'b0;
        win     = '0;
        cand    = '0;
        for (int i = 0; i < int'(CPU_NB); i++) begin
            cand = GNT_W'((int'(rr_ptr_q) + i) % int'(CPU_NB));
            if (!any_req && i_apb_s_psel[cand]) begin
                any_req = 1'b1;
                win     = cand;
            end
        end
    end

    // Next-state and registered-output decode
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        pready_d  = '0;
        prdata_d  = '0;
        pslverr_d = '0;
        mem_we    = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_d    = win;
                    addr_d   = i_apb_s_paddr[win];
                    write_d  = i_apb_s_pwrite[win];
                    wdata_d  = i_apb_s_pwdata[win];
                    strb_d   = i_apb_s_pstrb[win];
                    cnt_d    = CNT_W'(WAIT_CYCLES);
                    rr_ptr_d = GNT_W'((int'(win) + 1) % int'(CPU_NB));
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (!i_apb_s_psel[gnt_q]) begin
                    // Manager abandoned the transfer; nothing is accessed
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (i_apb_s_penable[gnt_q]) begin
                    if (in_range) begin
                        mem_we = write_q;
                        err_d  = 1'b0;
                        if (!write_q) begin
                            rdata_d = mem_rd;
                        end
                    end else begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end
                    // Response registers load on entry so they are valid for RESP only
                    pready_d[gnt_q]  = 1'b1;
                    prdata_d[gnt_q]  = rdata_d;
                    pslverr_d[gnt_q] = err_d;
                    state_d          = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            pready_q  <= '0;
            prdata_q  <= '0;
            pslverr_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            pready_q  <= pready_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
        end
    end

    // Memory array: not reset, and never written while reset is asserted
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (strb_q[b]) begin
                    mem[idx[MEM_AW-1:0]][b*8 +: 8] <= wdata_q[b*8 +: 8];
                end
            end
        end
    end

    assign o_apb_s_pready  = pready_q;
    assign o_apb_s_prdata  = prdata_q;
    assign o_apb_s_pslverr = pslverr_q;

endmodule
